// File: rtl/b4sq_credit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | b4sq_credit_pkg: shared TLP/FSM encodings and credit helper          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package b4sq_credit_pkg;

  typedef enum logic [1:0] {
    TLP_POSTED    = 2'd0,
    TLP_NONPOSTED = 2'd1,
    TLP_CPL       = 2'd2,
    TLP_RSVD      = 2'd3
  } tlp_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } rx_state_e;

  localparam int MAX_DATA_CREDITS = 256;

  // A Length of 0 with payload means 1024 DW, i.e. the full 256 credits.
  function automatic logic [8:0] dw_to_credits(input logic [9:0] len, input logic has_data);
    if (!has_data)
      return 9'd0;
    if (len == 10'd0)
      return 9'(MAX_DATA_CREDITS);
    return 9'((11'(len) + 11'd3) >> 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/b4sq_rx_credit_return.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | b4sq_rx_credit_return: turns consumed-TLP events into PCIe core      |
// | processed-credit pulses, skipping categories advertised as infinite. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module b4sq_rx_credit_return
  import b4sq_credit_pkg::*;
#(
  parameter int MAX_BATCH = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_fc_ph_infinite,
  input  logic        i_fc_pd_infinite,
  input  logic        i_fc_nph_infinite,
  input  logic        i_fc_npd_infinite,
  input  logic        i_tlp_valid,
  output logic        o_tlp_ready,
  input  logic [1:0]  i_tlp_type,
  input  logic        i_tlp_has_data,
  input  logic [9:0]  i_tlp_len_dw,
  output logic        o_ph_processed,
  output logic        o_pd_processed,
  output logic        o_nph_processed,
  output logic        o_npd_processed,
  output logic [7:0]  o_pd_num,
  output logic [7:0]  o_npd_num,
  output logic [15:0] o_ret_count
);

  localparam logic [8:0] c_batch = 9'(MAX_BATCH);

  rx_state_e   r_state;
  rx_state_e   w_next;
  logic [1:0]  r_type;
  logic        r_data_fin;
  logic [8:0]  r_rem;
  logic [15:0] r_ret_count;

  logic       w_xfer;
  logic       w_hdr_fin;
  logic       w_data_fin;
  logic [8:0] w_dc;
  logic [8:0] w_num;
  logic [8:0] w_rem_next;
  logic       w_posted;

  assign w_xfer     = i_tlp_valid && o_tlp_ready;
  assign w_dc       = dw_to_credits(i_tlp_len_dw, i_tlp_has_data);
  assign w_posted   = (r_type == TLP_POSTED);
  assign w_num      = (r_rem > c_batch) ? c_batch : r_rem;
  assign w_rem_next = r_rem - w_num;

  // Completions and reserved types resolve as "infinite" so they never leave IDLE.
  always_comb begin
    w_hdr_fin  = 1'b0;
    w_data_fin = 1'b0;
    if (i_tlp_type == TLP_POSTED) begin
      w_hdr_fin  = !i_fc_ph_infinite;
      w_data_fin = !i_fc_pd_infinite;
    end else if (i_tlp_type == TLP_NONPOSTED) begin
      w_hdr_fin  = !i_fc_nph_infinite;
      w_data_fin = !i_fc_npd_infinite;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next          = r_state;
    o_tlp_ready     = 1'b0;
    o_ph_processed  = 1'b0;
    o_pd_processed  = 1'b0;
    o_nph_processed = 1'b0;
    o_npd_processed = 1'b0;
    o_pd_num        = 8'd0;
    o_npd_num       = 8'd0;
    case (r_state)
      ST_IDLE: begin
        o_tlp_ready = 1'b1;
        if (w_xfer) begin
          if (w_hdr_fin)
            w_next = ST_HDR;
          else if (w_data_fin && (w_dc != 9'd0))
            w_next = ST_DATA;
        end
      end
      ST_HDR: begin
        o_ph_processed  = w_posted;
        o_nph_processed = !w_posted;
        w_next = (r_data_fin && (r_rem != 9'd0)) ? ST_DATA : ST_IDLE;
      end
      ST_DATA: begin
        o_pd_processed  = w_posted;
        o_npd_processed = !w_posted;
        o_pd_num        = w_posted ? w_num[7:0] : 8'd0;
        o_npd_num       = w_posted ? 8'd0 : w_num[7:0];
        w_next = (w_rem_next == 9'd0) ? ST_IDLE : ST_DATA;
      end
      default: w_next = ST_IDLE;
    endcase
    // Reset silences the outputs in the very cycle it is asserted.
    if (i_rst) begin
      o_tlp_ready     = 1'b0;
      o_ph_processed  = 1'b0;
      o_pd_processed  = 1'b0;
      o_nph_processed = 1'b0;
      o_npd_processed = 1'b0;
      o_pd_num        = 8'd0;
      o_npd_num       = 8'd0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_type      <= 2'd0;
      r_data_fin  <= 1'b0;
      r_rem       <= 9'd0;
      r_ret_count <= 16'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_xfer) begin
            r_type     <= i_tlp_type;
            r_data_fin <= w_data_fin;
            r_rem      <= w_dc;
          end
        end
        ST_HDR:  r_ret_count <= r_ret_count + 16'd1;
        ST_DATA: begin
          r_ret_count <= r_ret_count + 16'(w_num);
          r_rem       <= w_rem_next;
        end
        default: r_rem <= 9'd0;
      endcase
    end
  end

  assign o_ret_count = r_ret_count;

endmodule
`default_nettype wire
